// File: rtl/pulse_chk_pkg.sv
// Shared state encodings for the pulse width checker.
// State values are visible on the debug State port.
package pulse_chk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEAS     = 2'b01,
    REPORT   = 2'b10,
    WAIT_LOW = 2'b11
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Cycle counter: load forces 1, en increments until all-ones.
// sat is sticky once an increment is attempted at all-ones.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (load) begin
      count <= ONE;
      sat   <= 1'b0;
    end else if (en) begin
      if (count == MAX) sat <= 1'b1;
      else count <= count + ONE;
    end
  end

endmodule

// File: rtl/pulse_width_checker.sv
// Measures high pulses on X and reports width/err once per pulse.
// Define PULSE_TIMEOUT_EN to cut pulses longer than TIMEOUT cycles.
import pulse_chk_pkg::*;

module pulse_width_checker #(
  parameter int EXP_WIDTH = 3,
  parameter int CNT_W     = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             X,
  output logic [CNT_W-1:0] Width,
  output logic             Valid,
  output logic             Err,
  output logic             Timeout,
  output logic [1:0]       State
);

  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_WIDTH);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  state_t           state;
  state_t           nxt;
  logic             load;
  logic             en;
  logic             rep;
  logic             rep_to;
  logic [CNT_W-1:0] count;
  logic             sat;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (Clk),
    .rst_n (Rst),
    .load  (load),
    .en    (en),
    .count (count),
    .sat   (sat)
  );

  always_comb begin
    nxt    = state;
    load   = 1'b0;
    en     = 1'b0;
    rep    = 1'b0;
    rep_to = 1'b0;
    unique case (state)
      WAIT_LOW: begin
        if (!X) nxt = IDLE;
      end
      IDLE: begin
        if (X) begin
          nxt  = MEAS;
          load = 1'b1;
        end
      end
      MEAS: begin
        if (!X) begin
          nxt = REPORT;
          rep = 1'b1;
        end
`ifdef PULSE_TIMEOUT_EN
        else if (count == TO_CNT) begin
          nxt    = REPORT;
          rep    = 1'b1;
          rep_to = 1'b1;
        end
`endif
        else begin
          en = 1'b1;
        end
      end
      REPORT: begin
`ifdef PULSE_TIMEOUT_EN
        // Rest of a timed-out pulse is ignored until X falls.
        if (Timeout) nxt = WAIT_LOW;
        else
`endif
        if (X) begin
          nxt  = MEAS;
          load = 1'b1;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = WAIT_LOW;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= WAIT_LOW;
      Width   <= '0;
      Valid   <= 1'b0;
      Err     <= 1'b0;
      Timeout <= 1'b0;
    end else begin
      state <= nxt;
      Valid <= rep;
      if (rep) begin
        Width   <= rep_to ? TO_CNT : count;
        Err     <= rep_to | sat | (count != EXP_CNT);
        Timeout <= rep_to;
      end
    end
  end

  assign State = state;

endmodule

// File: tb/tb_pulse_width_checker.sv
// Randomized bench for pulse_width_checker against a pulse-level model.
// Honors PULSE_TIMEOUT_EN the same way as the design build.
module tb_pulse_width_checker;

  localparam int EXP_WIDTH = 3;
  localparam int CNT_W     = 4;
  localparam int TIMEOUT   = 8;
  localparam int MAXW      = (1 << CNT_W) - 1;

  logic             Clk;
  logic             Rst;
  logic             X;
  logic [CNT_W-1:0] Width;
  logic             Valid;
  logic             Err;
  logic             Timeout;
  logic [1:0]       State;

  int errors;
  int checks;
  int h_width;
  int h_err;
  int h_to;

  pulse_width_checker #(
    .EXP_WIDTH (EXP_WIDTH),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .X       (X),
    .Width   (Width),
    .Valid   (Valid),
    .Err     (Err),
    .Timeout (Timeout),
    .State   (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Pulse-level reference: report contents and the cycle (relative to
  // the first high sample) at which Valid is observed.
  function automatic void model(input int len, output int w,
                                output int e, output int t,
                                output int v);
`ifdef PULSE_TIMEOUT_EN
    if (len > TIMEOUT) begin
      w = TIMEOUT; e = 1; t = 1; v = TIMEOUT;
      return;
    end
`endif
    w = (len > MAXW) ? MAXW : len;
    e = ((len != EXP_WIDTH) || (len > MAXW)) ? 1 : 0;
    t = 0;
    v = len;
  endfunction

  function automatic bit cut(input int len);
`ifdef PULSE_TIMEOUT_EN
    return len > TIMEOUT;
`else
    return 1'b0;
`endif
  endfunction

  task automatic outs(input string tag);
    chk({tag, ".width"}, int'(Width), h_width);
    chk({tag, ".err"}, int'(Err), h_err);
    chk({tag, ".to"}, int'(Timeout), h_to);
  endtask

  task automatic run_pulse(input int len, input int gap);
    int w, e, t, v, g;
    model(len, w, e, t, v);
    g = (cut(len) && gap < 2) ? 2 : gap;
    for (int k = 0; k < len + g; k++) begin
      @(negedge Clk);
      X = (k < len);
      @(posedge Clk);
      #1;
      if (k == v) begin
        h_width = w;
        h_err   = e;
        h_to    = t;
      end
      chk("valid", int'(Valid), (k == v) ? 1 : 0);
      outs("rep");
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    h_width = 0;
    h_err   = 0;
    h_to    = 0;
    Rst     = 1'b0;
    X       = 1'b1;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst.state", int'(State), 3);
    chk("rst.valid", int'(Valid), 0);
    outs("rst");

    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) begin
      @(posedge Clk);
      #1;
      chk("wl.state", int'(State), 3);
      chk("wl.valid", int'(Valid), 0);
    end
    @(negedge Clk);
    X = 1'b0;
    @(posedge Clk);
    #1;
    chk("wl.idle", int'(State), 0);
    chk("wl.valid2", int'(Valid), 0);

    run_pulse(3, 2);
    run_pulse(1, 3);
    run_pulse(3, 1);
    run_pulse(5, 2);
    run_pulse(20, 3);
    run_pulse(12, 3);
    run_pulse(15, 2);
    run_pulse(16, 2);
    run_pulse(8, 1);
    run_pulse(9, 2);
    run_pulse(2, 1);

    // Asynchronous reset in the middle of a measurement.
    @(negedge Clk);
    X = 1'b1;
    repeat (2) @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    h_width = 0;
    h_err   = 0;
    h_to    = 0;
    chk("amid.state", int'(State), 3);
    chk("amid.valid", int'(Valid), 0);
    outs("amid");
    @(negedge Clk);
    X = 1'b0;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("amid.idle", int'(State), 0);
    chk("amid.valid2", int'(Valid), 0);

    for (int i = 0; i < 40; i++)
      run_pulse(int'($urandom_range(1, 20)), int'($urandom_range(1, 4)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
